// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: memory geometry, reset PC and the NOP encoding.
package mips_pkg;
  localparam int          ADDR_W    = 8;
  localparam int          DATA_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          RESET_PC  = 0;
endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register drives combinational imem, one-entry output
// register feeds decode over valid/ready, redirect flushes the held entry.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W_P   = ADDR_W,
  parameter int DATA_W_P   = DATA_W,
  parameter int RESET_PC_P = RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [ADDR_W_P-1:0] imem_addr,
  input  logic [DATA_W_P-1:0] imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W_P-1:0] redirect_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W_P-1:0] out_instr,
  output logic [ADDR_W_P-1:0] out_pc,
  output logic [15:0]         fetch_count
);

  localparam logic [ADDR_W_P-1:0] PC_RST = ADDR_W_P'(RESET_PC_P);

  logic [ADDR_W_P-1:0] pc;
  logic                load;
  logic                accept;

  // A fresh capture is possible only when the output slot is free or leaving.
  assign load      = en & (~out_valid | out_ready) & ~redirect_valid;
  assign accept    = out_valid & out_ready;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= PC_RST;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_addr;
      out_valid <= 1'b0;
    end else if (load) begin
      out_instr <= imem_rdata;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc + 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // Handshake completes before any same-cycle flush, so it is always counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (accept && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] pc,
                         input logic [31:0] ins, input logic [7:0] ia, input logic [15:0] cnt);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".pc"}, {24'd0, out_pc}, {24'd0, pc});
      chk({tag, ".instr"}, out_instr, ins);
    end
    chk({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, ia});
    chk({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    mem[0] = 32'h2001_0003;
    mem[1] = 32'h2002_0009;
    mem[2] = 32'h0022_1020;

    rst_n = 1'b0; en = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 8'h00;
    #12;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.pc", {24'd0, out_pc}, 32'd0);
    chk("rst.imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst.count", {16'd0, fetch_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    en = 1'b1;

    // streaming, then backpressure while pc=1 is held
    step(); chk_out("s0", 1'b1, 8'd0, 32'h2001_0003, 8'd1, 16'd0);
    step(); chk_out("s1", 1'b1, 8'd1, 32'h2002_0009, 8'd2, 16'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); chk_out("stall", 1'b1, 8'd1, 32'h2002_0009, 8'd2, 16'd1);
    end
    out_ready = 1'b1;
    step(); chk_out("s2", 1'b1, 8'd2, 32'h0022_1020, 8'd3, 16'd2);
    step(); chk_out("s3", 1'b1, 8'd3, 32'hA5A5_0003, 8'd4, 16'd3);

    // redirect while held and not accepted: flushed entry is not counted
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 8'h05;
    step(); chk_out("redir", 1'b0, 8'd0, 32'd0, 8'd5, 16'd3);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step(); chk_out("redir.tgt", 1'b1, 8'd5, 32'hA5A5_0005, 8'd6, 16'd3);

    // redirect coinciding with a handshake counts it; then wrap 0xFF -> 0x00
    redirect_valid = 1'b1; redirect_addr = 8'hFF;
    step(); chk_out("redir.hs", 1'b0, 8'd0, 32'd0, 8'hFF, 16'd4);
    redirect_valid = 1'b0;
    step(); chk_out("wrap.ff", 1'b1, 8'hFF, 32'hA5A5_00FF, 8'd0, 16'd4);
    step(); chk_out("wrap.00", 1'b1, 8'd0, 32'h2001_0003, 8'd1, 16'd5);

    // disable: held entry drains, pc frozen; resume at same pc
    en = 1'b0;
    step(); chk_out("dis0", 1'b0, 8'd0, 32'd0, 8'd1, 16'd6);
    step(); chk_out("dis1", 1'b0, 8'd0, 32'd0, 8'd1, 16'd6);
    step(); chk_out("dis2", 1'b0, 8'd0, 32'd0, 8'd1, 16'd6);
    en = 1'b1;
    step(); chk_out("resume", 1'b1, 8'd1, 32'h2002_0009, 8'd2, 16'd6);
    step(); chk_out("resume2", 1'b1, 8'd2, 32'h0022_1020, 8'd3, 16'd7);

    // asynchronous reset between edges takes effect immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("arst.count", {16'd0, fetch_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_out("post", 1'b1, 8'd0, 32'h2001_0003, 8'd1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
